// File: rtl/ref_gray_sync_bus.sv
// rtl/ref_gray_sync_bus.sv - multi-bit pointer crossing via Gray code and two-flop synchronizer
module ref_gray_sync_bus #(
  parameter int WIDTH = 8
) (
  input  logic             src_clk,
  input  logic             src_rst_n,
  input  logic [WIDTH-1:0] src_bin,
  input  logic             dst_clk,
  input  logic             dst_rst_n,
  output logic [WIDTH-1:0] dst_bin
);

  logic [WIDTH-1:0] src_gray;
  logic [WIDTH-1:0] meta_gray;
  logic [WIDTH-1:0] sync_gray;

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Registered in the source domain so only one bit moves per increment
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) src_gray <= '0;
    else            src_gray <= src_bin ^ (src_bin >> 1);
  end

  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      meta_gray <= '0;
      sync_gray <= '0;
    end else begin
      meta_gray <= src_gray;
      sync_gray <= meta_gray;
    end
  end

  assign dst_bin = gray_to_bin(sync_gray);

endmodule

// File: rtl/ref_inferred_block_ram.sv
// rtl/ref_inferred_block_ram.sv - simple dual-port RAM with registered read, separate clocks
module ref_inferred_block_ram #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 72
) (
  input  logic                  wr_clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_clk,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge wr_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge rd_clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ref_dc_fifo_commit_block_ram.sv
// rtl/ref_dc_fifo_commit_block_ram.sv - dual-clock FIFO whose writes become readable only on commit
module ref_dc_fifo_commit_block_ram #(
  parameter int ADDR_WIDTH        = 7,
  parameter int DATA_WIDTH        = 72,
  parameter int DLY_WR_FOR_RD_LVL = 1
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_commit,
  input  logic                  wr_abort,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_full,
  output logic [ADDR_WIDTH:0]   wr_pend_level,
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  rd_empty
);

  logic [ADDR_WIDTH:0] wr_addr, wr_cmt_addr, wr_addr_nxt, wr_cmt_nxt;
  logic [ADDR_WIDTH:0] wr_cmt_xfer, rd_addr_wr_sync, wr_diff;
  logic [ADDR_WIDTH:0] rd_addr, rd_addr_nxt, cmt_rd_sync, rd_diff;
  logic                ram_we, rd_inc;

  // An abort without commit drops the same-cycle word, so the RAM is not written
  always_comb begin
    ram_we      = wr_en && !wr_full && !(wr_abort && !wr_commit);
    wr_addr_nxt = wr_addr + {{ADDR_WIDTH{1'b0}}, ram_we};
    wr_cmt_nxt  = wr_cmt_addr;
    if (wr_commit)     wr_cmt_nxt  = wr_addr_nxt;
    else if (wr_abort) wr_addr_nxt = wr_cmt_addr;
    wr_diff = wr_addr_nxt - rd_addr_wr_sync;
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_addr       <= '0;
      wr_cmt_addr   <= '0;
      wr_level      <= '0;
      wr_full       <= 1'b0;
      wr_pend_level <= '0;
    end else begin
      wr_addr       <= wr_addr_nxt;
      wr_cmt_addr   <= wr_cmt_nxt;
      wr_level      <= wr_diff;
      wr_full       <= wr_diff[ADDR_WIDTH];
      wr_pend_level <= wr_addr_nxt - wr_cmt_nxt;
    end
  end

  generate
    if (DLY_WR_FOR_RD_LVL != 0) begin : g_cmt_dly
      logic [ADDR_WIDTH:0] wr_cmt_dly;
      always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) wr_cmt_dly <= '0;
        else           wr_cmt_dly <= wr_cmt_addr;
      end
      assign wr_cmt_xfer = wr_cmt_dly;
    end else begin : g_cmt_nodly
      assign wr_cmt_xfer = wr_cmt_addr;
    end
  endgenerate

  always_comb begin
    rd_inc      = rd_en && !rd_empty;
    rd_addr_nxt = rd_addr + {{ADDR_WIDTH{1'b0}}, rd_inc};
    rd_diff     = cmt_rd_sync - rd_addr_nxt;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_addr  <= '0;
      rd_level <= '0;
      rd_empty <= 1'b1;
    end else begin
      rd_addr  <= rd_addr_nxt;
      rd_level <= rd_diff;
      rd_empty <= (rd_diff == '0);
    end
  end

  ref_inferred_block_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .wr_clk  (wr_clk),
    .wr_en   (ram_we),
    .wr_addr (wr_addr[ADDR_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_clk  (rd_clk),
    .rd_addr (rd_addr[ADDR_WIDTH-1:0]),
    .rd_data (rd_data)
  );

  ref_gray_sync_bus #(.WIDTH(ADDR_WIDTH + 1)) u_cmt_sync (
    .src_clk   (wr_clk),
    .src_rst_n (wr_rst_n),
    .src_bin   (wr_cmt_xfer),
    .dst_clk   (rd_clk),
    .dst_rst_n (rd_rst_n),
    .dst_bin   (cmt_rd_sync)
  );

  ref_gray_sync_bus #(.WIDTH(ADDR_WIDTH + 1)) u_rd_sync (
    .src_clk   (rd_clk),
    .src_rst_n (rd_rst_n),
    .src_bin   (rd_addr),
    .dst_clk   (wr_clk),
    .dst_rst_n (wr_rst_n),
    .dst_bin   (rd_addr_wr_sync)
  );

`ifndef SYNTHESIS
  always @(posedge wr_clk) begin
    if (wr_rst_n && wr_en && wr_full)       $warning("wr_en while wr_full: word ignored");
    if (wr_rst_n && wr_commit && wr_abort)  $warning("wr_commit with wr_abort: abort ignored");
  end

  always @(posedge rd_clk) begin
    if (rd_rst_n && rd_en && rd_empty) $warning("rd_en while rd_empty: ignored");
  end
`endif

endmodule

// File: tb/tb_ref_dc_fifo_commit_block_ram.sv
// tb/tb_ref_dc_fifo_commit_block_ram.sv - randomized bench against a queue model of commit/abort FIFO
module tb_ref_dc_fifo_commit_block_ram;

  localparam int AW    = 4;
  localparam int DW    = 72;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 16;

  logic          wr_clk = 1'b0;
  logic          rd_clk = 1'b0;
  logic          wr_rst_n, rd_rst_n;
  logic          wr_en, wr_commit, wr_abort, rd_en;
  logic [DW-1:0] wr_data, rd_data;
  logic [PW-1:0] wr_level, wr_pend_level, rd_level;
  logic          wr_full, rd_empty;

  int wr_half = 5;
  int rd_half = 5;
  int errors  = 0;
  int checks  = 0;
  bit wr_done = 1'b0;

  logic [DW-1:0] cmt_q[$];
  logic [DW-1:0] pend_q[$];

  always #(wr_half) wr_clk = ~wr_clk;
  always #(rd_half) rd_clk = ~rd_clk;

  ref_dc_fifo_commit_block_ram #(
    .ADDR_WIDTH        (AW),
    .DATA_WIDTH        (DW),
    .DLY_WR_FOR_RD_LVL (1)
  ) dut (
    .wr_clk        (wr_clk),
    .wr_rst_n      (wr_rst_n),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .wr_commit     (wr_commit),
    .wr_abort      (wr_abort),
    .wr_level      (wr_level),
    .wr_full       (wr_full),
    .wr_pend_level (wr_pend_level),
    .rd_clk        (rd_clk),
    .rd_rst_n      (rd_rst_n),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_level      (rd_level),
    .rd_empty      (rd_empty)
  );

  function automatic logic [DW-1:0] rand_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // One write-side cycle; the model applies the same commit/abort rules at packet granularity
  task automatic wr_cycle(input bit en, input logic [DW-1:0] d, input bit c, input bit a);
    if (en && !(a && !c) && (cmt_q.size() + pend_q.size()) < DEPTH) pend_q.push_back(d);
    if (c) begin
      while (pend_q.size() > 0) cmt_q.push_back(pend_q.pop_front());
    end else if (a) begin
      pend_q.delete();
    end
    wr_en = en; wr_data = d; wr_commit = c; wr_abort = a;
    @(posedge wr_clk);
    @(negedge wr_clk);
    wr_en = 1'b0; wr_commit = 1'b0; wr_abort = 1'b0;
  endtask

  task automatic read_words(input int n, input string tag);
    logic [DW-1:0] exp;
    for (int i = 0; i < n; i++) begin
      int budget = 0;
      @(negedge rd_clk);
      while (rd_empty && budget < 50) begin
        @(negedge rd_clk);
        budget++;
      end
      checks++;
      if (rd_empty) begin
        errors++;
        $display("FAIL %s_wait word %0d: rd_empty=%0b required 0", tag, i, rd_empty);
        return;
      end
      checks++;
      if (cmt_q.size() == 0) begin
        errors++;
        $display("FAIL %s_underflow word %0d: data offered, model has 0 committed", tag, i);
        return;
      end
      exp = cmt_q.pop_front();
      checks++;
      if (rd_data !== exp) begin
        errors++;
        $display("FAIL %s_data word %0d: got %h required %h", tag, i, rd_data, exp);
      end
      rd_en = 1'b1;
      @(posedge rd_clk);
      @(negedge rd_clk);
      rd_en = 1'b0;
    end
  endtask

  task automatic test_reset;
    checks++; if (wr_level !== '0) begin errors++; $display("FAIL reset_wr_level: got %0d required 0", wr_level); end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL reset_wr_full: got %0b required 0", wr_full); end
    checks++; if (wr_pend_level !== '0) begin errors++; $display("FAIL reset_wr_pend: got %0d required 0", wr_pend_level); end
    checks++; if (rd_level !== '0) begin errors++; $display("FAIL reset_rd_level: got %0d required 0", rd_level); end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL reset_rd_empty: got %0b required 1", rd_empty); end
  endtask

  task automatic test_uncommitted;
    bit seen = 1'b0;
    for (int i = 0; i < 5; i++) wr_cycle(1'b1, rand_word(), 1'b0, 1'b0);
    checks++; if (wr_level !== PW'(5)) begin errors++; $display("FAIL uncmt_wr_level: got %0d required 5", wr_level); end
    checks++; if (wr_pend_level !== PW'(5)) begin errors++; $display("FAIL uncmt_wr_pend: got %0d required 5", wr_pend_level); end
    repeat (20) begin
      @(negedge rd_clk);
      if (rd_empty !== 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL uncmt_rd_empty: got 0 during 20 cycles required 1"); end
  endtask

  task automatic test_commit;
    int lat = 0;
    wr_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++; if (wr_pend_level !== '0) begin errors++; $display("FAIL commit_wr_pend: got %0d required 0", wr_pend_level); end
    while (rd_empty && lat < 6) begin
      @(negedge rd_clk);
      lat++;
    end
    checks++; if (rd_empty !== 1'b0) begin errors++; $display("FAIL commit_latency: rd_empty=%0b after %0d cycles required 0", rd_empty, lat); end
    checks++; if (rd_level !== PW'(5)) begin errors++; $display("FAIL commit_rd_level: got %0d required 5", rd_level); end
    read_words(5, "commit");
  endtask

  task automatic test_abort;
    for (int i = 0; i < 3; i++) wr_cycle(1'b1, rand_word(), 1'b0, 1'b0);
    wr_cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) wr_cycle(1'b1, rand_word(), 1'b0, 1'b0);
    wr_cycle(1'b0, '0, 1'b0, 1'b1);
    checks++; if (wr_pend_level !== '0) begin errors++; $display("FAIL abort_wr_pend: got %0d required 0", wr_pend_level); end
    checks++; if (wr_level !== PW'(cmt_q.size())) begin errors++; $display("FAIL abort_wr_level: got %0d required %0d", wr_level, cmt_q.size()); end
    for (int i = 0; i < 2; i++) wr_cycle(1'b1, rand_word(), 1'b0, 1'b0);
    wr_cycle(1'b0, '0, 1'b1, 1'b0);
    repeat (10) @(negedge rd_clk);
    checks++; if (rd_level !== PW'(5)) begin errors++; $display("FAIL abort_rd_level: got %0d required 5", rd_level); end
    read_words(5, "abort");
  endtask

  task automatic test_full;
    repeat (10) @(negedge wr_clk);
    for (int i = 0; i < 17; i++) wr_cycle(1'b1, rand_word(), 1'b0, 1'b0);
    checks++; if (wr_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %0b required 1", wr_full); end
    checks++; if (wr_level !== PW'(16)) begin errors++; $display("FAIL full_wr_level: got %0d required 16", wr_level); end
    checks++; if (wr_pend_level !== PW'(16)) begin errors++; $display("FAIL full_wr_pend: got %0d required 16", wr_pend_level); end
    wr_cycle(1'b0, '0, 1'b1, 1'b0);
    read_words(16, "full");
    repeat (4) @(negedge rd_clk);
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL drain_rd_empty: got %0b required 1", rd_empty); end
    checks++; if (rd_level !== '0) begin errors++; $display("FAIL drain_rd_level: got %0d required 0", rd_level); end
    repeat (8) @(negedge wr_clk);
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL drain_wr_full: got %0b required 0", wr_full); end
    checks++; if (wr_level !== '0) begin errors++; $display("FAIL drain_wr_level: got %0d required 0", wr_level); end
  endtask

  task automatic test_commit_abort_same;
    for (int i = 0; i < 2; i++) wr_cycle(1'b1, rand_word(), 1'b0, 1'b0);
    wr_cycle(1'b1, rand_word(), 1'b1, 1'b1);
    checks++; if (wr_pend_level !== '0) begin errors++; $display("FAIL cmtabt_wr_pend: got %0d required 0", wr_pend_level); end
    repeat (10) @(negedge rd_clk);
    checks++; if (rd_level !== PW'(3)) begin errors++; $display("FAIL cmtabt_rd_level: got %0d required 3", rd_level); end
    read_words(3, "cmtabt");
  endtask

  task automatic rand_writer;
    for (int p = 0; p < 100; p++) begin
      int len       = $urandom_range(1, 6);
      bit do_commit = ($urandom_range(0, 9) < 7);
      bit merged    = do_commit && ($urandom_range(0, 1) == 1);
      for (int w = 0; w < len; w++) begin
        int  budget = 0;
        bit  last   = (w == len - 1);
        while (wr_full && budget < 2000) begin
          @(negedge wr_clk);
          budget++;
        end
        checks++;
        if (wr_full) begin
          errors++;
          $display("FAIL rand_wr_full_stuck: wr_full=%0b after %0d cycles required 0", wr_full, budget);
          wr_done = 1'b1;
          return;
        end
        checks++;
        if (cmt_q.size() + pend_q.size() >= DEPTH) begin
          errors++;
          $display("FAIL rand_free_space: wr_full=0 with model occupancy %0d required <16", cmt_q.size() + pend_q.size());
        end
        wr_cycle(1'b1, rand_word(), last && merged, 1'b0);
        if (!(last && merged)) begin
          checks++;
          if (wr_pend_level !== PW'(pend_q.size())) begin
            errors++;
            $display("FAIL rand_wr_pend: got %0d required %0d", wr_pend_level, pend_q.size());
          end
        end
        checks++;
        if (int'(wr_level) < cmt_q.size() + pend_q.size() || int'(wr_level) > DEPTH) begin
          errors++;
          $display("FAIL rand_wr_level: got %0d required %0d..16", wr_level, cmt_q.size() + pend_q.size());
        end
        repeat ($urandom_range(0, 2)) @(negedge wr_clk);
      end
      if (!merged) wr_cycle(!wr_full && ($urandom_range(0, 1) == 1), rand_word(), do_commit, !do_commit);
      checks++;
      if (wr_pend_level !== '0) begin
        errors++;
        $display("FAIL rand_end_pend pkt %0d: got %0d required 0", p, wr_pend_level);
      end
    end
    wr_done = 1'b1;
  endtask

  task automatic rand_reader;
    logic [DW-1:0] exp;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      @(negedge rd_clk);
      if (wr_done && cmt_q.size() == 0) break;
      if (!rd_empty && $urandom_range(0, 3) != 0) begin
        checks++;
        if (int'(rd_level) > cmt_q.size()) begin
          errors++;
          $display("FAIL rand_rd_level: got %0d required <=%0d", rd_level, cmt_q.size());
        end
        checks++;
        if (cmt_q.size() == 0) begin
          errors++;
          $display("FAIL rand_underflow: rd_empty=0 with model committed 0");
        end else begin
          exp = cmt_q.pop_front();
          checks++;
          if (rd_data !== exp) begin
            errors++;
            $display("FAIL rand_rd_data: got %h required %h", rd_data, exp);
          end
        end
        rd_en = 1'b1;
        @(posedge rd_clk);
        @(negedge rd_clk);
        rd_en = 1'b0;
      end
    end
    checks++;
    if (!wr_done || cmt_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain_timeout: %0d words left, wr_done=%0b required 0 and 1", cmt_q.size(), wr_done);
    end
  endtask

  task automatic test_random;
    wr_half = 15;
    rd_half = 5;
    repeat (4) @(negedge wr_clk);
    fork
      rand_writer();
      rand_reader();
    join
    repeat (10) @(negedge wr_clk);
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL rand_final_rd_empty: got %0b required 1", rd_empty); end
    checks++; if (wr_level !== '0) begin errors++; $display("FAIL rand_final_wr_level: got %0d required 0", wr_level); end
    checks++; if (wr_full !== 1'b0) begin errors++; $display("FAIL rand_final_wr_full: got %0b required 0", wr_full); end
  endtask

  initial begin
    wr_en = 1'b0; wr_commit = 1'b0; wr_abort = 1'b0; rd_en = 1'b0;
    wr_data = '0;
    wr_rst_n = 1'b0; rd_rst_n = 1'b0;
    repeat (3) @(negedge wr_clk);
    test_reset();
    wr_rst_n = 1'b1; rd_rst_n = 1'b1;
    @(negedge wr_clk);
    test_uncommitted();
    test_commit();
    test_abort();
    test_full();
    test_commit_abort_same();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
